dmem_arbiter: RTL

Two-port arbiter sharing the single-port data memory between the MIPS core's load/store port (port 0) and a secondary master such as a loader or DMA engine (port 1). It grants one word access per cycle with round-robin fairness and supports a bounded lock for uninterrupted bursts. It drives the memory's address, write-data and write-enable pins, takes the combinational read data back, and returns a registered copy to the granted requester.

---
 rtl/dmem_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between two masters.
//   Port 0 is the core load/store port, port 1 a secondary master (loader/DMA).
//   One word access is granted per cycle, round-robin on ties, with a bounded
//   lock so a master can run an uninterrupted burst.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_reqN, i_weN, i_lockN  request, write select, lock request for port N
//   i_addrN, i_wdataN       byte address and write data for port N
//   o_gntN                  combinational grant for port N
//   o_rvalidN, o_rdataN     registered read response for port N
//   o_mem_addr, o_mem_wd,   memory address, write data and write enable
//   o_mem_we
//   i_mem_rd                combinational read data from the memory
module dmem_arbiter #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_we0,
  input  logic        i_we1,
  input  logic        i_lock0,
  input  logic        i_lock1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic        o_rvalid0,
  output logic        o_rvalid1,
  output logic [31:0] o_rdata0,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  output logic        o_mem_we,
  input  logic [31:0] i_mem_rd
);

  localparam int unsigned CntW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StOwn0,
    StOwn1
  } state_e;

  state_e            r_state, w_state_next;
  logic              r_last, w_last_next;    // last granted port (1 = port 1)
  logic [CntW-1:0]   r_lock_cnt, w_cnt_next;
  logic              r_rvalid0, r_rvalid1;
  logic [31:0]       r_rdata0, r_rdata1;

  logic              w_arb0, w_arb1;         // arbitration result before reset gating
  logic              w_gnt0, w_gnt1;

  // Arbitration: owner takes everything, otherwise single requester or round-robin.
  always_comb begin
    w_arb0 = 1'b0;
    w_arb1 = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_req0 && i_req1) begin
          w_arb0 = r_last;
          w_arb1 = ~r_last;
        end else begin
          w_arb0 = i_req0;
          w_arb1 = i_req1;
        end
      end
      StOwn0:  w_arb0 = i_req0;
      StOwn1:  w_arb1 = i_req1;
      default: ;
    endcase
  end

  // Grants are forced low while reset is asserted, even mid-cycle.
  assign w_gnt0 = w_arb0 & i_rst_n;
  assign w_gnt1 = w_arb1 & i_rst_n;

  // Ownership, fairness pointer and lock counter.
  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    w_cnt_next   = r_lock_cnt;

    if (w_gnt0) begin
      w_last_next = 1'b0;
    end else if (w_gnt1) begin
      w_last_next = 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        if (w_gnt0 && i_lock0) begin
          w_state_next = StOwn0;
          w_cnt_next   = '0;
        end else if (w_gnt1 && i_lock1) begin
          w_state_next = StOwn1;
          w_cnt_next   = '0;
        end
      end
      StOwn0: begin
        if ((w_gnt0 || !i_req0) && !i_lock0) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end else if (r_lock_cnt == CntW'(LOCK_MAX - 1)) begin
          // Forced release: marking port 0 as last hands the next tie to port 1.
          w_state_next = StIdle;
          w_cnt_next   = '0;
          w_last_next  = 1'b0;
        end else begin
          w_cnt_next = r_lock_cnt + CntW'(1);
        end
      end
      StOwn1: begin
        if ((w_gnt1 || !i_req1) && !i_lock1) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end else if (r_lock_cnt == CntW'(LOCK_MAX - 1)) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
          w_last_next  = 1'b1;
        end else begin
          w_cnt_next = r_lock_cnt + CntW'(1);
        end
      end
      default: begin
        w_state_next = StIdle;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_last     <= 1'b1;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_last     <= w_last_next;
      r_lock_cnt <= w_cnt_next;
    end
  end

  // Read responses: rvalid pulses after each read grant, rdata holds until the next read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~i_we0;
      r_rvalid1 <= w_gnt1 & ~i_we1;
      if (w_gnt0 && !i_we0) begin
        r_rdata0 <= i_mem_rd;
      end
      if (w_gnt1 && !i_we1) begin
        r_rdata1 <= i_mem_rd;
      end
    end
  end

  // Memory mux: port 0 fields are the idle default.
  always_comb begin
    if (w_gnt1) begin
      o_mem_addr = i_addr1;
      o_mem_wd   = i_wdata1;
      o_mem_we   = i_we1;
    end else begin
      o_mem_addr = i_addr0;
      o_mem_wd   = i_wdata0;
      o_mem_we   = w_gnt0 & i_we0;
    end
  end

  assign o_gnt0    = w_gnt0;
  assign o_gnt1    = w_gnt1;
  assign o_rvalid0 = r_rvalid0;
  assign o_rvalid1 = r_rvalid1;
  assign o_rdata0  = r_rdata0;
  assign o_rdata1  = r_rdata1;

endmodule
